// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, redirect and data-memory-wait stall/flush controller with perf counters
module hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_we,
    input  logic             ex_mem_read,
    input  logic [1:0]       ex_jump_t,
    input  logic             ex_branch_taken,
    input  logic             mem_mem_read,
    input  logic             mem_mem_write,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERR      = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic             freeze, redirect, load_use;

    assign freeze   = (mem_mem_read | mem_mem_write) & ~dmem_ready;
    assign redirect = ex_branch_taken | (ex_jump_t == 2'b01) | (ex_jump_t == 2'b10);
    assign load_use = ex_mem_read & ex_reg_we & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // Any state other than RUN/MEM_WAIT behaves as ERR so a corrupted state stays safe.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        stall_d     = stall_q;
        flush_d     = flush_q;
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_we    = 1'b0;
        ex_mem_we   = 1'b0;
        mem_wb_we   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (rst) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (state_q != RUN && state_q != MEM_WAIT) begin
            mem_err_d = 1'b1;
        end else if (freeze) begin
            stall_d = stall_q + CNT_W'(1);
            if (state_q == RUN) begin
                state_d    = MEM_WAIT;
                wait_cnt_d = 16'd1;
            end else if (wait_cnt_q == 16'(MEM_TIMEOUT)) begin
                state_d   = ERR;
                mem_err_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 16'd1;
            end
        end else begin
            state_d    = RUN;
            wait_cnt_d = 16'd0;
            id_ex_we   = 1'b1;
            ex_mem_we  = 1'b1;
            mem_wb_we  = 1'b1;
            if (redirect) begin
                pc_we       = 1'b1;
                if_id_we    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                flush_d     = flush_q + CNT_W'(1);
            end else if (load_use) begin
                id_ex_flush = 1'b1;
                stall_d     = stall_q + CNT_W'(1);
            end else begin
                pc_we    = 1'b1;
                if_id_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= 16'd0;
            mem_err_q  <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
endmodule
